// File: rtl/data_port_arbiter_pkg.sv
// data_port_arbiter_pkg
//   Shared types and constants for the data port arbiter and its tag FIFO.
//   MAX_MASTERS : upper bound on requesters; sizes the index type.
//   idx_t       : requester index, also the tag FIFO entry type.
//   lock_state_e: request-lock FSM states.
package data_port_arbiter_pkg;

  localparam int MAX_MASTERS = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

endpackage

// File: rtl/data_port_arbiter_tag_fifo.sv
// data_port_arbiter_tag_fifo
//   In-order FIFO of requester indices. One entry is pushed per downstream
//   grant and popped per downstream response, so the head always names the
//   requester that owns the next response.
//   clk_i, rst_ni : clock, asynchronous active-low reset (flushes the FIFO)
//   push_i        : write push_data_i (ignored when full)
//   push_data_i   : requester index to record
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : oldest stored index
//   full_o/empty_o: occupancy flags
module data_port_arbiter_tag_fifo
  import data_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  idx_t push_data_i,
  input  logic pop_i,
  output idx_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  idx_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wrap_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/data_port_arbiter.sv
// data_port_arbiter
//   Shares one req/gnt/rvalid data port between NUM_MASTERS requesters.
//   Selection is round-robin (or fixed priority when the macro
//   DATA_ARB_FIXED_PRIO_EN is defined), frozen while a downstream request is
//   waiting for its grant, and responses are routed back in order through a
//   tag FIFO of MAX_OUTSTANDING entries.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   m_req_i/m_gnt_o        : per-requester request and grant
//   m_addr_i, m_we_i, m_be_i, m_wdata_i : per-requester access fields
//   m_rvalid_o, m_rdata_o  : per-requester response (rdata zero when idle)
//   s_req_o/s_gnt_i        : downstream request and grant
//   s_addr_o, s_we_o, s_be_o, s_wdata_o : selected access fields
//   s_rvalid_i, s_rdata_i  : downstream response
//   busy_o                 : transactions outstanding or request locked
module data_port_arbiter
  import data_port_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,  // 2..4
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2   // 1..4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NUM_MASTERS-1:0]                 m_req_i,
  output logic [NUM_MASTERS-1:0]                 m_gnt_o,
  output logic [NUM_MASTERS-1:0]                 m_rvalid_o,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_MASTERS-1:0][3:0]            m_be_i,
  input  logic [NUM_MASTERS-1:0][31:0]           m_wdata_i,
  output logic [NUM_MASTERS-1:0][31:0]           m_rdata_o,
  output logic                                   s_req_o,
  input  logic                                   s_gnt_i,
  input  logic                                   s_rvalid_i,
  output logic [ADDR_WIDTH-1:0]                  s_addr_o,
  output logic                                   s_we_o,
  output logic [3:0]                             s_be_o,
  output logic [31:0]                            s_wdata_o,
  input  logic [31:0]                            s_rdata_i,
  output logic                                   busy_o
);

  // Requester inputs padded to MAX_MASTERS so an idx_t selects exactly.
  logic [MAX_MASTERS-1:0]                 req_pad;
  logic [MAX_MASTERS-1:0][ADDR_WIDTH-1:0] addr_pad;
  logic [MAX_MASTERS-1:0]                 we_pad;
  logic [MAX_MASTERS-1:0][3:0]            be_pad;
  logic [MAX_MASTERS-1:0][31:0]           wdata_pad;

  for (genvar gi = 0; gi < MAX_MASTERS; gi++) begin : g_pad
    if (gi < NUM_MASTERS) begin : g_real
      assign req_pad[gi]   = m_req_i[gi];
      assign addr_pad[gi]  = m_addr_i[gi];
      assign we_pad[gi]    = m_we_i[gi];
      assign be_pad[gi]    = m_be_i[gi];
      assign wdata_pad[gi] = m_wdata_i[gi];
    end else begin : g_absent
      assign req_pad[gi]   = 1'b0;
      assign addr_pad[gi]  = '0;
      assign we_pad[gi]    = 1'b0;
      assign be_pad[gi]    = '0;
      assign wdata_pad[gi] = '0;
    end
  end

  lock_state_e state_q, state_d;
  idx_t        lock_idx_q, lock_idx_d;
  idx_t        search_start;
  idx_t        arb_sel, sel, cand;
  logic        found;
  logic        grant;
  logic        fifo_full, fifo_empty, fifo_pop;
  idx_t        fifo_head;

  // Full blocks requests even if a pop lands in the same cycle, keeping
  // s_req_o independent of s_rvalid_i.
  assign s_req_o  = (|m_req_i) & ~fifo_full;
  assign grant    = s_req_o & s_gnt_i;
  assign fifo_pop = s_rvalid_i & ~fifo_empty;
  assign busy_o   = ~fifo_empty | (state_q == LOCKED);

`ifdef DATA_ARB_FIXED_PRIO_EN
  assign search_start = '0;
`else
  idx_t rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) rr_ptr_d = (sel == idx_t'(NUM_MASTERS - 1)) ? '0 : sel + idx_t'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end

  assign search_start = rr_ptr_q;
`endif

  // First requester at or after search_start, wrapping within NUM_MASTERS.
  always_comb begin
    found   = 1'b0;
    arb_sel = search_start;
    cand    = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = idx_t'((int'(search_start) + k) % NUM_MASTERS);
      if (!found && req_pad[cand]) begin
        found   = 1'b1;
        arb_sel = cand;
      end
    end
  end

  // Once the downstream side has seen a request it may have started issuing
  // it, so the selection is frozen until that request is granted.
  assign sel = (state_q == LOCKED) ? lock_idx_q : arb_sel;

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      UNLOCKED: begin
        if (s_req_o && !s_gnt_i) begin
          state_d    = LOCKED;
          lock_idx_d = sel;
        end
      end
      LOCKED: begin
        if (s_gnt_i) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= UNLOCKED;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign s_addr_o  = addr_pad[sel];
  assign s_we_o    = we_pad[sel];
  assign s_be_o    = be_pad[sel];
  assign s_wdata_o = wdata_pad[sel];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_route
    assign m_gnt_o[gi]    = grant & (sel == idx_t'(gi));
    assign m_rvalid_o[gi] = fifo_pop & (fifo_head == idx_t'(gi));
    assign m_rdata_o[gi]  = m_rvalid_o[gi] ? s_rdata_i : '0;
  end

  data_port_arbiter_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (grant),
    .push_data_i(sel),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

`ifndef SYNTHESIS
  a_rvalid_needs_tag : assert property (
    @(posedge clk_i) disable iff (!rst_ni) s_rvalid_i |-> !fifo_empty)
    else $error("s_rvalid_i with no outstanding transaction");

  a_locked_req_held : assert property (
    @(posedge clk_i) disable iff (!rst_ni) (state_q == LOCKED) |-> req_pad[lock_idx_q])
    else $error("locked requester dropped m_req_i");
`endif

endmodule

// File: tb/tb_data_port_arbiter.sv
module tb_data_port_arbiter;
  import data_port_arbiter_pkg::*;

  localparam int NM = 2;
  localparam int AW = 32;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NM-1:0]          m_req_i;
  logic [NM-1:0]          m_gnt_o;
  logic [NM-1:0]          m_rvalid_o;
  logic [NM-1:0][AW-1:0]  m_addr_i;
  logic [NM-1:0]          m_we_i;
  logic [NM-1:0][3:0]     m_be_i;
  logic [NM-1:0][31:0]    m_wdata_i;
  logic [NM-1:0][31:0]    m_rdata_o;
  logic                   s_req_o;
  logic                   s_gnt_i;
  logic                   s_rvalid_i;
  logic [AW-1:0]          s_addr_o;
  logic                   s_we_o;
  logic [3:0]             s_be_o;
  logic [31:0]            s_wdata_o;
  logic [31:0]            s_rdata_i;
  logic                   busy_o;

  data_port_arbiter #(
    .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
    .m_addr_i(m_addr_i), .m_we_i(m_we_i), .m_be_i(m_be_i),
    .m_wdata_i(m_wdata_i), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
    .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
    .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } resp_t;

  int    n_cmp = 0;
  int    n_err = 0;
  int    tag_q[$];   // model: granted requesters in order
  resp_t sb_q[$];    // expected responses

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_grant(input string tag, input int idx);
    chk(tag, 64'(m_gnt_o), 64'(1) << idx);
    tag_q.push_back(idx);
    $display("grant  -> m%0d addr %08h", idx, s_addr_o);
  endtask

  task automatic drive_resp(input logic [31:0] d);
    resp_t r;
    s_rvalid_i = 1'b1;
    s_rdata_i  = d;
    if (tag_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL model: response with no granted transaction");
      r.idx = 0;
    end else begin
      r.idx = tag_q.pop_front();
    end
    r.data = d;
    sb_q.push_back(r);
  endtask

  task automatic check_resp();
    resp_t r;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard: empty at response check");
    end else begin
      r = sb_q.pop_front();
      chk("resp_rvalid", 64'(m_rvalid_o), 64'(1) << r.idx);
      chk("resp_rdata", 64'(m_rdata_o), 64'(r.data) << (32 * r.idx));
      $display("resp   -> m%0d data %08h", r.idx, r.data);
    end
  endtask

  initial begin
    int exp_idx;
    rst_ni = 1'b0; m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_be_i = '0;
    m_wdata_i = '0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    #1;
    chk("rst_gnt", 64'(m_gnt_o), 0);
    chk("rst_rvalid", 64'(m_rvalid_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_sreq", 64'(s_req_o), 0);
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b1;
    tick();

    // Fairness: both requesting, downstream always grants and answers.
    m_addr_i[0] = 32'h0000_0100;
    m_addr_i[1] = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
`ifdef DATA_ARB_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = i % 2;
`endif
      m_req_i = 2'b11;
      s_gnt_i = 1'b1;
      if (i > 0) drive_resp(32'h0000_0100 + 32'(i));
      else       s_rvalid_i = 1'b0;
      #1;
      if (i > 0) check_resp();
      expect_grant("rr_gnt", exp_idx);
      chk("rr_addr", 64'(s_addr_o), (exp_idx == 0) ? 64'h100 : 64'h200);
      tick();
    end
    m_req_i = '0;
    s_gnt_i = 1'b0;
    drive_resp(32'h0000_01FF);
    #1 check_resp();
    tick();
    s_rvalid_i = 1'b0;
    #1 chk("rr_idle_busy", 64'(busy_o), 0);

    // Single requester read.
    m_req_i = 2'b01; m_addr_i[0] = 32'h0000_1000; m_we_i = '0; s_gnt_i = 1'b1;
    #1;
    chk("single_sreq", 64'(s_req_o), 1);
    expect_grant("single_gnt", 0);
    chk("single_addr", 64'(s_addr_o), 64'h1000);
    chk("single_we", 64'(s_we_o), 0);
    tick();
    m_req_i = '0; s_gnt_i = 1'b0;
    #1;
    chk("single_busy", 64'(busy_o), 1);
    chk("single_no_rvalid", 64'(m_rvalid_o), 0);
    tick();
    drive_resp(32'hDEAD_BEEF);
    #1 check_resp();
    tick();
    s_rvalid_i = 1'b0;
    #1 chk("single_done_busy", 64'(busy_o), 0);

    // Lock: requester 0 waits three cycles, requester 1 joins meanwhile.
    m_addr_i[0] = 32'h0000_A000; m_addr_i[1] = 32'h0000_B000;
    m_we_i = 2'b01; m_wdata_i[0] = 32'hCAFE_0000; m_be_i[0] = 4'hF;
    m_req_i = 2'b01; s_gnt_i = 1'b0;
    #1;
    chk("lock_sreq", 64'(s_req_o), 1);
    chk("lock_no_gnt", 64'(m_gnt_o), 0);
    chk("lock_addr0", 64'(s_addr_o), 64'hA000);
    tick();
    chk("lock_addr1", 64'(s_addr_o), 64'hA000);
    chk("lock_busy", 64'(busy_o), 1);
    tick();
    m_req_i = 2'b11;
    #1;
    chk("lock_addr2", 64'(s_addr_o), 64'hA000);
    chk("lock_we", 64'(s_we_o), 1);
    chk("lock_wdata", 64'(s_wdata_o), 64'hCAFE_0000);
    chk("lock_be", 64'(s_be_o), 64'hF);
    tick();
    s_gnt_i = 1'b1;
    #1;
    expect_grant("lock_gnt", 0);
    chk("lock_gnt_addr", 64'(s_addr_o), 64'hA000);
    tick();
    m_req_i = 2'b10;
    #1;
    expect_grant("after_lock_gnt", 1);
    chk("after_lock_addr", 64'(s_addr_o), 64'hB000);
    tick();

    // FIFO now holds two tags: requests are blocked, also during the pop.
    m_req_i = 2'b01;
    #1;
    chk("full_sreq", 64'(s_req_o), 0);
    chk("full_gnt", 64'(m_gnt_o), 0);
    chk("full_busy", 64'(busy_o), 1);
    tick();
    drive_resp(32'h5A5A_0001);
    #1;
    check_resp();
    chk("full_pop_sreq", 64'(s_req_o), 0);
    chk("full_pop_gnt", 64'(m_gnt_o), 0);
    tick();
    s_rvalid_i = 1'b0;
    #1;
    chk("refill_sreq", 64'(s_req_o), 1);
    expect_grant("refill_gnt", 0);
    tick();
    m_req_i = '0; s_gnt_i = 1'b0;
    drive_resp(32'h5A5A_0002);
    #1 check_resp();
    tick();
    drive_resp(32'h5A5A_0003);
    #1 check_resp();
    tick();
    s_rvalid_i = 1'b0;
    #1 chk("drain_busy", 64'(busy_o), 0);

    // In-order routing: grants 1 then 0.
    m_req_i = 2'b10; s_gnt_i = 1'b1;
    #1 expect_grant("ord_gnt1", 1);
    tick();
    m_req_i = 2'b01;
    #1 expect_grant("ord_gnt0", 0);
    tick();
    m_req_i = '0; s_gnt_i = 1'b0;
    drive_resp(32'h0000_0011);
    #1 check_resp();
    tick();
    drive_resp(32'h0000_0022);
    #1 check_resp();
    tick();
    s_rvalid_i = 1'b0;

    // Reset with one transaction outstanding.
    m_req_i = 2'b01; s_gnt_i = 1'b1;
    #1 expect_grant("pre_rst_gnt", 0);
    tick();
    m_req_i = '0; s_gnt_i = 1'b0;
    #1 chk("pre_rst_busy", 64'(busy_o), 1);
    rst_ni = 1'b0;
    tag_q.delete();
    #1;
    chk("mid_rst_busy", 64'(busy_o), 0);
    chk("mid_rst_sreq", 64'(s_req_o), 0);
    s_rvalid_i = 1'b1; s_rdata_i = 32'hBAD0_BAD0;
    #1;
    chk("stray_rvalid", 64'(m_rvalid_o), 0);
    chk("stray_rdata", 64'(m_rdata_o), 0);
    $display("stray  -> response ignored after reset");
    tick();
    s_rvalid_i = 1'b0;
    #2 rst_ni = 1'b1;
    tick();
    m_req_i = 2'b01;
    #1;
    chk("post_rst_sreq", 64'(s_req_o), 1);
    chk("post_rst_busy", 64'(busy_o), 0);
    m_req_i = '0;
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
